// File: rtl/m62_rom_loader_pkg.sv
// rtl/m62_rom_loader_pkg.sv - shared types and region map for the ROM download path
package m62_dl_pkg;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_ACK} dl_state_e;

  typedef struct packed {
    logic [24:0] addr;
    logic [7:0]  data;
  } dl_entry_t;

  localparam logic [24:0] M62_SP_BASE   = 25'h30000;
  localparam logic [24:0] M62_PROM_BASE = 25'hA0000;

  // Byte lane select for a 16-bit SDRAM word: odd bytes use the upper lane.
  function automatic logic [1:0] byte_sel(input logic a0);
    return {a0, ~a0};
  endfunction

endpackage

// File: rtl/m62_rom_loader_if.sv
// rtl/m62_rom_loader_if.sv - toggle-handshake write ports 1 and 2 towards the SDRAM controller
interface m62_rom_loader_if;
  logic        port1_req;
  logic        port1_ack;
  logic [22:0] port1_a;
  logic [1:0]  port1_ds;
  logic [15:0] port1_d;
  logic        port1_we;
  logic        port2_req;
  logic        port2_ack;
  logic [22:0] port2_a;
  logic [1:0]  port2_ds;
  logic [15:0] port2_d;
  logic        port2_we;

  modport master (
    output port1_req, port1_a, port1_ds, port1_d, port1_we,
    output port2_req, port2_a, port2_ds, port2_d, port2_we,
    input  port1_ack, port2_ack
  );

  modport slave (
    input  port1_req, port1_a, port1_ds, port1_d, port1_we,
    input  port2_req, port2_a, port2_ds, port2_d, port2_we,
    output port1_ack, port2_ack
  );
endinterface

// File: rtl/m62_rom_loader_fifo.sv
// rtl/m62_rom_loader_fifo.sv - small synchronous FIFO of download entries; pushes on full are dropped
module m62_dl_fifo
  import m62_dl_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  dl_entry_t     push_data,
  input  logic          pop,
  output dl_entry_t     pop_data,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  localparam int AW = $clog2(DEPTH);

  dl_entry_t     mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push, do_pop;

  assign full     = (count_q == CW'(DEPTH));
  assign empty    = (count_q == '0);
  assign count    = count_q;
  assign pop_data = mem_q[rd_ptr_q];

  always_comb begin
    do_push  = push & ~full;
    do_pop   = pop & ~empty;
    wr_ptr_d = wr_ptr_q + AW'(do_push);
    rd_ptr_d = rd_ptr_q + AW'(do_pop);
    count_d  = count_q + CW'(do_push) - CW'(do_pop);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/m62_rom_loader.sv
// rtl/m62_rom_loader.sv - ioctl byte stream to SDRAM port1/port2 writes, PROM strobes and core reset stretch
// Optional rom_sum byte checksum output when ROM_CHECKSUM_EN is defined.
module m62_rom_loader
  import m62_dl_pkg::*;
#(
  parameter int          FIFO_DEPTH = 4,
  parameter logic [24:0] SP_BASE    = M62_SP_BASE,
  parameter logic [24:0] PROM_BASE  = M62_PROM_BASE,
  parameter int          RST_W      = 16
) (
  input  logic             clk_sys,
  input  logic             reset_n,
  input  logic             ioctl_download,
  input  logic             ioctl_wr,
  input  logic [24:0]      ioctl_addr,
  input  logic [7:0]       ioctl_dout,
  output logic             ioctl_wait,
  input  logic             reset_req,
  m62_rom_loader_if.master sdram,
  output logic             prom_wr,
  output logic [11:0]      prom_addr,
  output logic [7:0]       prom_d,
  output logic             rom_loaded,
  output logic             core_reset,
  output logic             ovf_err
`ifdef ROM_CHECKSUM_EN
  ,
  output logic [15:0]      rom_sum
`endif
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  dl_state_e       state_q, state_d;
  dl_entry_t       cap_q, cap_d, hold_q, hold_d, pop_data;
  logic            wr_r_q, wr_r_d, wr_rr_q, wr_rr_d, dl_r_q, dl_r_d, dl_rr_q, dl_rr_d;
  logic            p1_req_q, p1_req_d, p1_we_q, p1_we_d;
  logic            p2_req_q, p2_req_d, p2_we_q, p2_we_d, p2_pend_q, p2_pend_d;
  logic            prom_wr_q, prom_wr_d;
  logic [11:0]     prom_addr_q, prom_addr_d;
  logic [7:0]      prom_data_q, prom_data_d;
  logic            wait_q, wait_d, ovf_q, ovf_d, loaded_q, loaded_d, armed_q, armed_d;
  logic            core_reset_q, core_reset_d;
  logic [RST_W-1:0] rst_cnt_q, rst_cnt_d;
  logic            push, pop, full, empty, dl_rise, dl_fall, loaded_set, p1_done, p2_done;
  logic [CW-1:0]   count;
  logic [23:0]     p2_off;
  logic [11:0]     prom_off;

  // Inputs are registered first, so the write edge is detected one cycle after hps_io drives it.
  assign push    = wr_r_q & ~wr_rr_q & dl_r_q;
  assign dl_rise = dl_r_q & ~dl_rr_q;
  assign dl_fall = ~dl_r_q & dl_rr_q;
  assign p2_off  = hold_q.addr[23:0] - SP_BASE[23:0];
  assign prom_off = hold_q.addr[11:0] - PROM_BASE[11:0];

  m62_dl_fifo #(.DEPTH(FIFO_DEPTH), .CW(CW)) u_fifo (
    .clk       (clk_sys),
    .rst_n     (reset_n),
    .push      (push),
    .push_data (cap_q),
    .pop       (pop),
    .pop_data  (pop_data),
    .full      (full),
    .empty     (empty),
    .count     (count)
  );

  always_comb begin
    wr_r_d      = ioctl_wr;
    wr_rr_d     = wr_r_q;
    dl_r_d      = ioctl_download;
    dl_rr_d     = dl_r_q;
    cap_d       = '{addr: ioctl_addr, data: ioctl_dout};
    state_d     = state_q;
    hold_d      = hold_q;
    pop         = 1'b0;
    p1_req_d    = p1_req_q;
    p1_we_d     = p1_we_q;
    p2_req_d    = p2_req_q;
    p2_we_d     = p2_we_q;
    p2_pend_d   = p2_pend_q;
    prom_wr_d   = 1'b0;
    prom_addr_d = prom_addr_q;
    prom_data_d = prom_data_q;
    p1_done     = (sdram.port1_ack == p1_req_q);
    p2_done     = !p2_pend_q || (sdram.port2_ack == p2_req_q);

    case (state_q)
      IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          hold_d  = pop_data;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        p1_req_d  = ~p1_req_q;
        p1_we_d   = 1'b1;
        p2_pend_d = (hold_q.addr >= SP_BASE);
        if (hold_q.addr >= SP_BASE) begin
          p2_req_d = ~p2_req_q;
          p2_we_d  = 1'b1;
        end
        if (hold_q.addr >= PROM_BASE) begin
          prom_wr_d   = 1'b1;
          prom_addr_d = prom_off;
          prom_data_d = hold_q.data;
        end
        state_d = WAIT_ACK;
      end
      WAIT_ACK: begin
        if (p1_done) p1_we_d = 1'b0;
        if (p2_done) p2_we_d = 1'b0;
        if (p1_done && p2_done) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // A download counts as loaded only once every queued byte has been acknowledged.
    loaded_set = armed_q && (state_q == IDLE) && empty && !push;
    armed_d    = dl_rise ? 1'b0 : (dl_fall ? 1'b1 : (loaded_set ? 1'b0 : armed_q));
    loaded_d   = dl_rise ? 1'b0 : (loaded_set ? 1'b1 : loaded_q);
    ovf_d      = ovf_q | (push & full);
    wait_d     = (count >= CW'(FIFO_DEPTH - 1));

    if (reset_req || !loaded_q || ioctl_download) rst_cnt_d = '1;
    else if (rst_cnt_q != '0)                     rst_cnt_d = rst_cnt_q - 1'b1;
    else                                          rst_cnt_d = rst_cnt_q;
    core_reset_d = (rst_cnt_d != '0);
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      wr_r_q       <= 1'b0;
      wr_rr_q      <= 1'b0;
      dl_r_q       <= 1'b0;
      dl_rr_q      <= 1'b0;
      cap_q        <= '0;
      state_q      <= IDLE;
      hold_q       <= '0;
      p1_req_q     <= 1'b0;
      p1_we_q      <= 1'b0;
      p2_req_q     <= 1'b0;
      p2_we_q      <= 1'b0;
      p2_pend_q    <= 1'b0;
      prom_wr_q    <= 1'b0;
      prom_addr_q  <= '0;
      prom_data_q  <= '0;
      wait_q       <= 1'b0;
      ovf_q        <= 1'b0;
      loaded_q     <= 1'b0;
      armed_q      <= 1'b0;
      rst_cnt_q    <= '1;
      core_reset_q <= 1'b1;
    end else begin
      wr_r_q       <= wr_r_d;
      wr_rr_q      <= wr_rr_d;
      dl_r_q       <= dl_r_d;
      dl_rr_q      <= dl_rr_d;
      cap_q        <= cap_d;
      state_q      <= state_d;
      hold_q       <= hold_d;
      p1_req_q     <= p1_req_d;
      p1_we_q      <= p1_we_d;
      p2_req_q     <= p2_req_d;
      p2_we_q      <= p2_we_d;
      p2_pend_q    <= p2_pend_d;
      prom_wr_q    <= prom_wr_d;
      prom_addr_q  <= prom_addr_d;
      prom_data_q  <= prom_data_d;
      wait_q       <= wait_d;
      ovf_q        <= ovf_d;
      loaded_q     <= loaded_d;
      armed_q      <= armed_d;
      rst_cnt_q    <= rst_cnt_d;
      core_reset_q <= core_reset_d;
    end
  end

  assign sdram.port1_req = p1_req_q;
  assign sdram.port1_we  = p1_we_q;
  assign sdram.port1_a   = hold_q.addr[23:1];
  assign sdram.port1_ds  = byte_sel(hold_q.addr[0]);
  assign sdram.port1_d   = {2{hold_q.data}};
  assign sdram.port2_req = p2_req_q;
  assign sdram.port2_we  = p2_we_q;
  assign sdram.port2_a   = p2_off[23:1];
  assign sdram.port2_ds  = byte_sel(p2_off[0]);
  assign sdram.port2_d   = {2{hold_q.data}};
  assign ioctl_wait      = wait_q;
  assign prom_wr         = prom_wr_q;
  assign prom_addr       = prom_addr_q;
  assign prom_d          = prom_data_q;
  assign rom_loaded      = loaded_q;
  assign core_reset      = core_reset_q;
  assign ovf_err         = ovf_q;

`ifdef ROM_CHECKSUM_EN
  logic [15:0] sum_q, sum_d;

  always_comb begin
    sum_d = sum_q;
    if (dl_rise)                                 sum_d = '0;
    else if ((state_q == ISSUE) && !loaded_q)    sum_d = sum_q + {8'h00, hold_q.data};
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) sum_q <= '0;
    else          sum_q <= sum_d;
  end

  assign rom_sum = sum_q;
`endif

endmodule

// File: tb/tb_m62_rom_loader.sv
// tb/tb_m62_rom_loader.sv - scoreboard bench for m62_rom_loader: SDRAM ack model, request monitor, directed steps
module tb_m62_rom_loader;
  import m62_dl_pkg::*;

  logic        clk_sys = 1'b0;
  logic        reset_n, ioctl_download, ioctl_wr, reset_req;
  logic [24:0] ioctl_addr;
  logic [7:0]  ioctl_dout;
  logic        ioctl_wait, prom_wr, rom_loaded, core_reset, ovf_err;
  logic [11:0] prom_addr;
  logic [7:0]  prom_d;
`ifdef ROM_CHECKSUM_EN
  logic [15:0] rom_sum;
`endif

  m62_rom_loader_if sif ();

  m62_rom_loader #(.RST_W(4)) dut (
    .clk_sys        (clk_sys),
    .reset_n        (reset_n),
    .ioctl_download (ioctl_download),
    .ioctl_wr       (ioctl_wr),
    .ioctl_addr     (ioctl_addr),
    .ioctl_dout     (ioctl_dout),
    .ioctl_wait     (ioctl_wait),
    .reset_req      (reset_req),
    .sdram          (sif),
    .prom_wr        (prom_wr),
    .prom_addr      (prom_addr),
    .prom_d         (prom_d),
    .rom_loaded     (rom_loaded),
    .core_reset     (core_reset),
    .ovf_err        (ovf_err)
`ifdef ROM_CHECKSUM_EN
    ,
    .rom_sum        (rom_sum)
`endif
  );

  always #5 clk_sys = ~clk_sys;

  int ntotal = 0, npass = 0, nfail = 0;
  int cyc = 0, wr_cyc = 0;
  int ack_dly1 = 4, ack_dly2 = 4;
  bit ack_en = 1'b1, lat_chk = 1'b0, saw_wait = 1'b0;
  dl_entry_t q1[$], q2[$], qp[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntotal++;
    assert (obs === exp) npass++;
    else begin
      nfail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; honours ioctl_wait like hps_io and records the expected SDRAM/PROM traffic.
  task automatic send_byte(input logic [24:0] addr, input logic [7:0] data);
    int n = 0;
    dl_entry_t e;
    while (ioctl_wait && n < 500) begin
      saw_wait = 1'b1;
      @(negedge clk_sys);
      n++;
    end
    check("wait_bound", n < 500, 1);
    e.addr = addr;
    e.data = data;
    q1.push_back(e);
    if (addr >= 25'h30000) q2.push_back(e);
    if (addr >= 25'hA0000) qp.push_back(e);
    ioctl_addr = addr;
    ioctl_dout = data;
    ioctl_wr   = 1'b1;
    wr_cyc     = cyc + 1;
    @(negedge clk_sys);
    ioctl_wr = 1'b0;
    @(negedge clk_sys);
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while ((q1.size() != 0 || q2.size() != 0 || sif.port1_we || sif.port2_we) && n < 400) begin
      @(negedge clk_sys);
      n++;
    end
    check({tag, "_drain"}, n < 400, 1);
    check({tag, "_q1"}, q1.size(), 0);
    check({tag, "_q2"}, q2.size(), 0);
    check({tag, "_qp"}, qp.size(), 0);
  endtask

  // SDRAM ack model: answers an outstanding toggle after a programmable number of cycles.
  initial begin
    sif.port1_ack = 1'b0;
    forever begin
      @(posedge clk_sys); #3;
      if (!reset_n) sif.port1_ack = 1'b0;
      else if (ack_en && (sif.port1_req !== sif.port1_ack)) begin
        repeat (ack_dly1) @(posedge clk_sys);
        #3;
        sif.port1_ack = reset_n ? sif.port1_req : 1'b0;
      end
    end
  end

  initial begin
    sif.port2_ack = 1'b0;
    forever begin
      @(posedge clk_sys); #3;
      if (!reset_n) sif.port2_ack = 1'b0;
      else if (ack_en && (sif.port2_req !== sif.port2_ack)) begin
        repeat (ack_dly2) @(posedge clk_sys);
        #3;
        sif.port2_ack = reset_n ? sif.port2_req : 1'b0;
      end
    end
  end

  // Request monitor: every toggle/strobe pops the scoreboard and checks the presented word.
  initial begin : monitor
    logic p1_prev, p2_prev, p1_tog, p2_tog;
    logic [24:0] off;
    dl_entry_t e;
    p1_prev = 1'b0;
    p2_prev = 1'b0;
    forever begin
      @(posedge clk_sys);
      cyc++;
      #1;
      if (!reset_n) begin
        p1_prev = 1'b0;
        p2_prev = 1'b0;
      end else begin
        p1_tog = (sif.port1_req !== p1_prev);
        p2_tog = (sif.port2_req !== p2_prev);
        if (p1_tog) begin
          check("p1_expected", q1.size() != 0, 1);
          check("p1_prev_acked", sif.port1_ack, p1_prev);
          check("p2_prev_acked", sif.port2_ack, p2_prev);
          check("p1_we", sif.port1_we, 1);
          if (lat_chk) begin
            check("latency", cyc - wr_cyc, 3);
            lat_chk = 1'b0;
          end
          if (q1.size() != 0) begin
            e = q1.pop_front();
            check("p1_a", sif.port1_a, e.addr >> 1);
            check("p1_ds", sif.port1_ds, e.addr[0] ? 2'b10 : 2'b01);
            check("p1_d", sif.port1_d, {e.data, e.data});
          end
        end
        if (p2_tog) begin
          check("p2_with_p1", p1_tog, 1);
          check("p2_expected", q2.size() != 0, 1);
          check("p2_we", sif.port2_we, 1);
          if (q2.size() != 0) begin
            e = q2.pop_front();
            off = e.addr - 25'h30000;
            check("p2_a", sif.port2_a, off >> 1);
            check("p2_ds", sif.port2_ds, off[0] ? 2'b10 : 2'b01);
            check("p2_d", sif.port2_d, {e.data, e.data});
          end
        end
        if (prom_wr) begin
          check("prom_with_p1", p1_tog, 1);
          check("prom_expected", qp.size() != 0, 1);
          if (qp.size() != 0) begin
            e = qp.pop_front();
            off = e.addr - 25'hA0000;
            check("prom_addr", prom_addr, off & 25'hFFF);
            check("prom_d", prom_d, e.data);
          end
        end
        p1_prev = sif.port1_req;
        p2_prev = sif.port2_req;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    int n;
    reset_n = 1'b0;
    ioctl_download = 1'b0;
    ioctl_wr = 1'b0;
    ioctl_addr = '0;
    ioctl_dout = '0;
    reset_req = 1'b0;
    repeat (3) @(negedge clk_sys);
    check("rst_p1_req", sif.port1_req, 0);
    check("rst_p2_req", sif.port2_req, 0);
    check("rst_p1_we", sif.port1_we, 0);
    check("rst_wait", ioctl_wait, 0);
    check("rst_prom_wr", prom_wr, 0);
    check("rst_loaded", rom_loaded, 0);
    check("rst_core_reset", core_reset, 1);
    check("rst_ovf", ovf_err, 0);
    reset_n = 1'b1;
    @(negedge clk_sys);
    ioctl_download = 1'b1;
    repeat (3) @(negedge clk_sys);

    // 1: plain low byte, only port1
    ack_dly1 = 4;
    lat_chk = 1'b1;
    send_byte(25'h00005, 8'hA5);
    wait_idle("t1");
    check("t1_lat_seen", lat_chk, 0);

    // 2: sprite region, port2 acks later than port1
    ack_dly1 = 2;
    ack_dly2 = 8;
    send_byte(25'h30001, 8'h3C);
    send_byte(25'h30002, 8'h55);
    wait_idle("t2");

    // 3: PROM region
    ack_dly1 = 3;
    ack_dly2 = 3;
    send_byte(25'hA0003, 8'h0F);
    wait_idle("t3");

    // 4: back-to-back with slow acks fills the FIFO to the wait threshold
    ack_dly1 = 10;
    saw_wait = 1'b0;
    for (int i = 0; i < 8; i++) send_byte(25'h00200 + 25'(i), 8'(8'h10 + i));
    wait_idle("t4");
    check("t4_saw_wait", saw_wait, 1);
    check("t4_no_ovf", ovf_err, 0);

    // 5: end of download with two bytes still queued
    send_byte(25'h00010, 8'h01);
    send_byte(25'h00011, 8'h02);
    ioctl_download = 1'b0;
    repeat (2) @(negedge clk_sys);
    check("t5_not_loaded_yet", rom_loaded, 0);
    n = 0;
    while (!rom_loaded && n < 300) begin
      @(negedge clk_sys);
      n++;
    end
    check("t5_loaded_bound", n < 300, 1);
    check("t5_q1_drained", q1.size(), 0);
    check("t5_acked", sif.port1_ack, sif.port1_req);
    check("t5_reset_held", core_reset, 1);
    n = 0;
    while (core_reset && n < 40) begin
      @(negedge clk_sys);
      n++;
    end
    check("t5_stretch", n, 15);
    reset_req = 1'b1;
    @(negedge clk_sys);
    check("t5_reset_req", core_reset, 1);
    reset_req = 1'b0;
    check("t5_still_loaded", rom_loaded, 1);

    // 6: new download, stall acks, overflow, then reset_n mid-transfer
    ioctl_download = 1'b1;
    repeat (3) @(negedge clk_sys);
    check("t6_loaded_clear", rom_loaded, 0);
    ack_en = 1'b0;
    send_byte(25'h00100, 8'h77);
    n = 0;
    while (!sif.port1_we && n < 20) begin
      @(negedge clk_sys);
      n++;
    end
    check("t6_issued", sif.port1_we, 1);
    for (int i = 0; i < 8; i++) begin
      ioctl_addr = 25'h00101 + 25'(i);
      ioctl_wr = 1'b1;
      @(negedge clk_sys);
      ioctl_wr = 1'b0;
      @(negedge clk_sys);
    end
    @(negedge clk_sys);
    check("t6_ovf", ovf_err, 1);
    check("t6_wait_full", ioctl_wait, 1);
    reset_n = 1'b0;
    @(negedge clk_sys);
    check("t6_p1_req", sif.port1_req, 0);
    check("t6_p2_req", sif.port2_req, 0);
    check("t6_p1_we", sif.port1_we, 0);
    check("t6_wait", ioctl_wait, 0);
    check("t6_prom_wr", prom_wr, 0);
    check("t6_loaded", rom_loaded, 0);
    check("t6_core_reset", core_reset, 1);
    check("t6_ovf_clr", ovf_err, 0);
`ifdef ROM_CHECKSUM_EN
    check("t6_sum_rst", rom_sum, 16'h0000);
`endif
    check("t6_q1", q1.size(), 0);
    reset_n = 1'b1;
    ack_en = 1'b1;
    ack_dly1 = 2;
    repeat (10) @(negedge clk_sys);
    check("t6_fifo_empty", sif.port1_req, 0);
    check("t6_wait_after", ioctl_wait, 0);
`ifdef ROM_CHECKSUM_EN
    send_byte(25'h00040, 8'hFF);
    send_byte(25'h00041, 8'h02);
    wait_idle("t6s");
    check("t6_rom_sum", rom_sum, 16'h0101);
`endif

    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end

endmodule
